// File: rtl/pipelined_carry_skip_adder.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready flow control.
// WIDTH must be a non-zero multiple of BLOCK.
module pipelined_carry_skip_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4,
  localparam int unsigned NumBlocks = WIDTH / BLOCK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic                 overflow,
  output logic [NumBlocks-1:0] skip_mask
);

  // Stage 1 combinational: effective operands and per-block propagate/generate
  logic [WIDTH-1:0]     bb, p1, g1, rc1;
  logic                 c0;
  logic [NumBlocks-1:0] grp_p, grp_g;

  assign bb = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;
  assign p1 = a ^ bb;
  assign g1 = a & bb;

  for (genvar k = 0; k < NumBlocks; k++) begin : g_s1_blk
    for (genvar j = 0; j < BLOCK; j++) begin : g_s1_bit
      // Block ripple with carry-in 0; the last bit gives the group generate
      if (j == 0) begin : g_first
        assign rc1[k*BLOCK+j] = g1[k*BLOCK+j];
      end else begin : g_rest
        assign rc1[k*BLOCK+j] = g1[k*BLOCK+j] | (p1[k*BLOCK+j] & rc1[k*BLOCK+j-1]);
      end
    end
    assign grp_p[k] = &p1[k*BLOCK +: BLOCK];
    assign grp_g[k] = rc1[k*BLOCK+BLOCK-1];
  end

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_bb_q;
  logic                 s1_c0_q;
  logic [NumBlocks-1:0] s1_p_q, s1_g_q;

  // Stage 2 combinational: skip chain across blocks, ripple inside each block
  logic [NumBlocks:0]   blk_c;
  logic [WIDTH-1:0]     bit_c, sum_d;
  logic                 cout_d, ovf_d;

  assign blk_c[0] = s1_c0_q;

  for (genvar k = 0; k < NumBlocks; k++) begin : g_s2_blk
    assign blk_c[k+1] = s1_p_q[k] ? blk_c[k] : s1_g_q[k];
    for (genvar j = 0; j < BLOCK; j++) begin : g_s2_bit
      if (j == 0) begin : g_first
        assign bit_c[k*BLOCK+j] = blk_c[k];
      end else begin : g_rest
        assign bit_c[k*BLOCK+j] = (s1_a_q[k*BLOCK+j-1] & s1_bb_q[k*BLOCK+j-1]) |
                                  ((s1_a_q[k*BLOCK+j-1] ^ s1_bb_q[k*BLOCK+j-1]) &
                                   bit_c[k*BLOCK+j-1]);
      end
      assign sum_d[k*BLOCK+j] = s1_a_q[k*BLOCK+j] ^ s1_bb_q[k*BLOCK+j] ^ bit_c[k*BLOCK+j];
    end
  end

  assign cout_d = blk_c[NumBlocks];
  assign ovf_d  = bit_c[WIDTH-1] ^ blk_c[NumBlocks];

  // Flow control
  logic out_valid_q, out_valid_d;
  logic s1_load, s2_load;

  assign in_ready = !s1_valid_q | !out_valid_q | out_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & (!out_valid_q | out_ready);

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s2_load) s1_valid_d = 1'b0;
    if (s1_load) s1_valid_d = 1'b1;
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (s2_load)   out_valid_d = 1'b1;
  end

  // Stage 2 registers
  logic [WIDTH-1:0]     sum_q;
  logic                 cout_q, ovf_q;
  logic [NumBlocks-1:0] skip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_bb_q     <= '0;
      s1_c0_q     <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      skip_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_load) begin
        s1_a_q  <= a;
        s1_bb_q <= bb;
        s1_c0_q <= c0;
        s1_p_q  <= grp_p;
        s1_g_q  <= grp_g;
      end
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        skip_q <= s1_p_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign skip_mask = skip_q;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench: directed cases, backpressure, mid-stream reset and
// randomized traffic against an arithmetic reference model.
module tb_pipelined_carry_skip_adder;
  localparam int unsigned W   = 16;
  localparam int unsigned BLK = 4;
  localparam int unsigned NB  = W / BLK;
  localparam int unsigned EW  = W + 2 + NB;
  localparam int unsigned NRand = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic [NB-1:0] skip_mask;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int accepted = 0;
  logic [EW-1:0] exp_q[$];
  logic          stall_prev = 1'b0;
  logic [EW-1:0] stall_val = '0;

  always #5 clk = ~clk;

  pipelined_carry_skip_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .skip_mask (skip_mask)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands
  function automatic logic [EW-1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic tcin, input logic tsub);
    logic [W-1:0]  eb;
    logic [W:0]    full;
    longint        sa, sb, r;
    logic          ovf;
    logic [NB-1:0] m;
    longint unsigned diff, blk_all;
    eb   = tsub ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, (tsub | tcin)};
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb));
    r    = tsub ? (sa - sb) : (sa + sb + longint'(tcin));
    ovf  = (r > (longint'(1) <<< (W - 1)) - 1) || (r < -(longint'(1) <<< (W - 1)));
    diff    = longint'(ta ^ eb);
    blk_all = (longint'(1) << BLK) - 1;
    for (int k = 0; k < int'(NB); k++) m[k] = ((diff >> (k * BLK)) & blk_all) == blk_all;
    return {full[W-1:0], full[W], ovf, m};
  endfunction

  // One cycle: evaluate handshakes mid-cycle, then advance past the next edge
  task automatic tick();
    logic [EW-1:0] obs;
    @(negedge clk);
    obs = {sum, cout, overflow, skip_mask};
    if (stall_prev) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(obs), 64'(stall_val));
    end
    if (out_valid && out_ready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("result", 64'(obs), 64'(exp_q.pop_front()));
        delivered++;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_val  = obs;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin, sub));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic [NB-1:0] em);
    out_ready = 1'b1;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(overflow), 64'(eo));
    chk({name, "_mask"}, 64'(skip_mask), 64'(em));
    tick();
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb);
    a = ta; b = tb; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
  endtask

  initial begin
    int d0, a0, cyc;
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_mask", 64'(skip_mask), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add_ff_1",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0010);
    directed("sub_5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b1110);
    directed("sub_7_5",   16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 4'b1110);
    directed("ovf_7fff",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110);
    directed("full_skip", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111);

    // Backpressure: two beats fill the pipe, the third stalls
    out_ready = 1'b0;
    d0 = delivered;
    drive(16'h1111, 16'h0101); tick();
    drive(16'h2222, 16'h0202); tick();
    drive(16'h3333, 16'h0303);
    chk("bp_c_stalled", 64'(in_ready), 64'd0);
    tick();
    chk("bp_c_still_stalled", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_delivered", 64'(delivered - d0), 64'd3);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(16'hAAAA, 16'h5555); tick();
    drive(16'h1234, 16'h4321); tick();
    in_valid = 1'b0;
    chk("pre_reset_full", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_cout", 64'(cout), 64'd0);
    chk("mid_rst_mask", 64'(skip_mask), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      chk("no_stale", 64'(out_valid), 64'd0);
      tick();
    end

    // Randomized traffic with random backpressure
    a0 = accepted;
    cyc = 0;
    while ((accepted - a0) < int'(NRand) && cyc < 40000) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 9) != 0) && ((accepted - a0) < int'(NRand) - 1 ||
                 !(in_valid && in_ready));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_accepted", 64'(accepted - a0), 64'(NRand));
    out_ready = 1'b1;
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, two-stage pipelined carry-skip adder/subtractor for the arithmetic library. It generalises the single carry-skip block to WIDTH bits split into WIDTH/BLOCK skip blocks, and adds an add/subtract mode, signed overflow and a per-block skip-taken report. A valid/ready handshake with full backpressure lets it sit directly in streaming datapaths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of BLOCK, ≥ BLOCK
- BLOCK, 4, bits per skip block; NUM_BLOCKS = WIDTH/BLOCK
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a−b (a + ~b + 1)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- overflow  output  1  signed overflow of the operation
- skip_mask  output  NUM_BLOCKS  bit k = 1 when block k's carry-in bypassed the block (all bits of block k propagate)

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Per bit: g = a & bb, p = a ^ bb (exclusive-or propagate; the skip condition uses p, never a|bb).
- Stage 1 (S1), registered on accept: a, bb, c0, per-block group-propagate P[k] = &p[block k], per-block group-generate/ripple carry-out G[k] computed with block carry-in 0.
- Stage 2 (S2), registered from S1: block carry chain c[k+1] = P[k] ? c[k] : G'[k], where G'[k] is the block ripple carry-out for its actual carry-in; sums formed by rippling inside each block from c[k]. skip_mask[k] = P[k]. cout = c[NUM_BLOCKS]. overflow = carry into MSB XOR carry out of MSB.
- Result is bit-identical to (a + bb + c0) mod 2^WIDTH; cout is bit WIDTH of that sum.
- Handshake: a beat transfers on in_valid & in_ready; output transfers on out_valid & out_ready. in_valid/operands are sampled only on transfer. Outputs hold stable while out_valid & !out_ready.
- Flow: S2 loads from S1 when S2 empty or out_ready; S1 loads when S1 empty or moving to S2. in_ready = !s1_valid | !out_valid | out_ready (combinational, no dependence on in_valid).
- Order preserved; no beat dropped or duplicated.

## Timing
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+1 (two register stages: input at N, result at N+1).
- Throughput: one beat per cycle with out_ready held high.
- Capacity: two beats in flight; with out_ready=0, third beat stalls (in_ready=0).
- Reset (rst_n low, any time, asynchronous): s1_valid=0, out_valid=0, sum=0, cout=0, overflow=0, skip_mask=0; in-flight beats discarded; in_ready=1 once rst_n is low (both stages empty). First accept possible on first edge after rst_n rises.
- Simultaneous accept and output transfer when full: both occur same edge; occupancy unchanged.
- WIDTH == BLOCK: single block, skip_mask 1 bit, behaviour otherwise identical.

## Test plan
- WIDTH=16, BLOCK=4, add a=0x00FF b=0x0001 cin=0 -> two cycles later sum=0x0100, cout=0, overflow=0, skip_mask=4'b0010.
- Subtract a=0x0005 b=0x0007 sub=1 -> sum=0xFFFE, cout=0, overflow=0; a=0x0007 b=0x0005 sub=1 -> sum=0x0002, cout=1.
- Overflow/full-skip: a=0x7FFF b=0x0001 -> sum=0x8000, overflow=1, cout=0; a=0xFFFF b=0x0000 cin=1 -> sum=0x0000, cout=1, skip_mask=4'b1111.
- Backpressure: out_ready=0, in_valid=1 with beats A,B,C -> A,B accepted, in_ready=0 for C; raise out_ready -> A,B,C delivered in order, one per cycle, no loss.
- Reset mid-stream: two beats in flight, pulse rst_n low between edges -> outputs immediately 0, out_valid=0, in_ready=1; stale beats never appear after release.
- Random: 10k back-to-back beats, random out_ready, WIDTH∈{8,16,32}, BLOCK∈{2,4,8} -> every result matches reference model (a+bb+c0), overflow, skip_mask.
